// File: rtl/square_osc_pkg.sv
// Shared types and helpers for the multichannel square-wave oscillator.
// Contents:
//   state_t      - sequencer states (IDLE, RUN, MIX)
//   DUTY_BITS    - width of a per-channel duty threshold
//   AMP_BITS     - width of a per-channel amplitude
//   OUT_WIDTH    - width of the mixed audio sample
//   saturate_u16 - clamps a wide unsigned sum to the 16-bit sample range
package square_osc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    MIX  = 2'd2
  } state_t;

  localparam int DUTY_BITS = 8;
  localparam int AMP_BITS  = 16;
  localparam int OUT_WIDTH = 16;

  // Callers zero-extend their accumulator to 32 bits; any value above the
  // 16-bit range pins to full scale instead of wrapping.
  function automatic logic [OUT_WIDTH-1:0] saturate_u16(input logic [31:0] v);
    if (v > 32'h0000_FFFF) begin
      return 16'hFFFF;
    end
    return v[OUT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/square_osc_slew_filter.sv
// First-order slew filter applied to the mixed sample, modelling the RC
// softening of the square-wave edges.
// Ports:
//   clk     - system clock
//   reset_n - asynchronous active-low reset, clears the output to 0
//   strobe  - one-cycle update request (the MIX cycle)
//   target  - saturated mix for the current sample
//   out     - filtered sample, held between strobes
// With SLEW_SHIFT = 0 the output simply follows the target. Otherwise each
// update moves the output by (target - out) >>> SLEW_SHIFT, computed in
// 18-bit signed arithmetic so the arithmetic shift floors toward -inf.
module square_osc_slew_filter
  import square_osc_pkg::*;
#(
  parameter int SLEW_SHIFT = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 strobe,
  input  logic [OUT_WIDTH-1:0] target,
  output logic [OUT_WIDTH-1:0] out
);

  logic signed [17:0] diff;
  logic signed [17:0] step;
  logic signed [17:0] sum;
  logic [OUT_WIDTH-1:0] out_d;

  always_comb begin
    diff  = $signed({2'b00, target}) - $signed({2'b00, out});
    step  = diff >>> SLEW_SHIFT;
    // out + step always lies between out and target, so it fits 16 bits.
    sum   = $signed({2'b00, out}) + step;
    out_d = target;
    if (SLEW_SHIFT != 0) begin
      out_d = 16'(sum);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out <= '0;
    end else if (strobe) begin
      out <= out_d;
    end
  end

endmodule

// File: rtl/multichannel_square_wave_oscillator.sv
// Multichannel square-wave oscillator with saturating mixer and optional
// slew filter. One adder is shared across channels: after a sample strobe
// the sequencer visits one channel per clock (RUN), then saturates and
// filters the sum (MIX), then returns to IDLE.
// Ports:
//   clk, reset_n  - system clock, asynchronous active-low reset
//   audio_clk_en  - sample strobe (one clk wide)
//   phase_inc     - per-channel phase increment, channel i at [i*PHASE_BITS +: PHASE_BITS]
//   duty          - per-channel 8-bit duty threshold
//   amplitude     - per-channel 16-bit unsigned high level
//   ch_enable     - per-channel enable
//   phase_reset   - clears all phase accumulators
//   out           - mixed 16-bit unsigned sample
//   out_valid     - one-cycle pulse when out updates
//   busy          - a sample is in progress
//   overrun       - sticky, a strobe arrived while busy
module multichannel_square_wave_oscillator
  import square_osc_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int PHASE_BITS   = 24,
  parameter int SLEW_SHIFT   = 0
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               audio_clk_en,
  input  logic [NUM_CHANNELS*PHASE_BITS-1:0] phase_inc,
  input  logic [NUM_CHANNELS*DUTY_BITS-1:0]  duty,
  input  logic [NUM_CHANNELS*AMP_BITS-1:0]   amplitude,
  input  logic [NUM_CHANNELS-1:0]            ch_enable,
  input  logic                               phase_reset,
  output logic [OUT_WIDTH-1:0]               out,
  output logic                               out_valid,
  output logic                               busy,
  output logic                               overrun
);

  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  // Wide enough for NUM_CHANNELS full-scale amplitudes, so the sum never wraps.
  localparam int ACC_W = AMP_BITS + $clog2(NUM_CHANNELS);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CHANNELS - 1);

  state_t state_q, state_d;

  logic                  accept;
  logic                  run_step;
  logic                  mix_step;
  logic                  strobe_lost;

  logic [CH_W-1:0]       ch_q;
  logic [ACC_W-1:0]      acc_q;
  logic [PHASE_BITS-1:0] phase_q [NUM_CHANNELS];
  logic                  reset_pend_q;

  logic [PHASE_BITS-1:0] cur_inc;
  logic [DUTY_BITS-1:0]  cur_duty;
  logic [AMP_BITS-1:0]   cur_amp;
  logic                  cur_en;
  logic [PHASE_BITS-1:0] cur_phase_next;
  logic                  cur_level;
  logic [AMP_BITS-1:0]   contrib;
  logic [OUT_WIDTH-1:0]  target;

  // ---- sequencer ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    run_step    = 1'b0;
    mix_step    = 1'b0;
    strobe_lost = 1'b0;
    case (state_q)
      IDLE: begin
        if (audio_clk_en) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        run_step    = 1'b1;
        strobe_lost = audio_clk_en;
        if (ch_q == LAST_CH) begin
          state_d = MIX;
        end
      end
      MIX: begin
        mix_step    = 1'b1;
        strobe_lost = audio_clk_en;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // ---- shared channel datapath (RUN) ----
  always_comb begin
    cur_inc        = phase_inc[ch_q*PHASE_BITS +: PHASE_BITS];
    cur_duty       = duty[ch_q*DUTY_BITS +: DUTY_BITS];
    cur_amp        = amplitude[ch_q*AMP_BITS +: AMP_BITS];
    cur_en         = ch_enable[ch_q];
    cur_phase_next = phase_q[ch_q] + cur_inc;
    // Top 8 phase bits against the threshold: duty 0 never high, 255 high
    // for all but the last 1/256 of the period.
    cur_level      = (cur_phase_next[PHASE_BITS-1 -: DUTY_BITS] < cur_duty);
    contrib        = (cur_en && cur_level) ? cur_amp : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch_q         <= '0;
      acc_q        <= '0;
      reset_pend_q <= 1'b0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        phase_q[i] <= '0;
      end
    end else begin
      out_valid <= mix_step;
      if (strobe_lost) begin
        overrun <= 1'b1;
      end

      if (accept) begin
        acc_q <= '0;
        ch_q  <= '0;
      end

      // In IDLE the clear is immediate, so a coincident strobe runs from
      // zeroed phases.
      if (state_q == IDLE && phase_reset) begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
          phase_q[i] <= '0;
        end
      end

      if (run_step) begin
        phase_q[ch_q] <= cur_en ? cur_phase_next : '0;
        acc_q         <= acc_q + ACC_W'(contrib);
        ch_q          <= ch_q + 1'b1;
        // Deferred so the sample in flight finishes with consistent phases.
        if (phase_reset) begin
          reset_pend_q <= 1'b1;
        end
      end

      if (mix_step) begin
        if (reset_pend_q || phase_reset) begin
          for (int i = 0; i < NUM_CHANNELS; i++) begin
            phase_q[i] <= '0;
          end
        end
        reset_pend_q <= 1'b0;
      end
    end
  end

  // ---- mix and slew (MIX) ----
  assign target = saturate_u16(32'(acc_q));

  square_osc_slew_filter #(
    .SLEW_SHIFT(SLEW_SHIFT)
  ) u_slew (
    .clk    (clk),
    .reset_n(reset_n),
    .strobe (mix_step),
    .target (target),
    .out    (out)
  );

endmodule

// File: tb/tb_multichannel_square_wave_oscillator.sv
// Bench for multichannel_square_wave_oscillator with NUM_CHANNELS=4,
// PHASE_BITS=24. Two instances share every input: dut0 without slew filter,
// dut2 with SLEW_SHIFT=2.
module tb_multichannel_square_wave_oscillator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        audio_clk_en = 1'b0;
  logic        phase_reset = 1'b0;
  logic [95:0] phase_inc = '0;
  logic [31:0] duty = '0;
  logic [63:0] amplitude = '0;
  logic [3:0]  ch_enable = '0;

  logic [15:0] out0, out2;
  logic        ov0, ov2, busy0, busy2, orn0, orn2;

  multichannel_square_wave_oscillator #(
    .NUM_CHANNELS(4), .PHASE_BITS(24), .SLEW_SHIFT(0)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .audio_clk_en(audio_clk_en),
    .phase_inc(phase_inc), .duty(duty), .amplitude(amplitude),
    .ch_enable(ch_enable), .phase_reset(phase_reset),
    .out(out0), .out_valid(ov0), .busy(busy0), .overrun(orn0)
  );

  multichannel_square_wave_oscillator #(
    .NUM_CHANNELS(4), .PHASE_BITS(24), .SLEW_SHIFT(2)
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .audio_clk_en(audio_clk_en),
    .phase_inc(phase_inc), .duty(duty), .amplitude(amplitude),
    .ch_enable(ch_enable), .phase_reset(phase_reset),
    .out(out2), .out_valid(ov2), .busy(busy2), .overrun(orn2)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
    $fatal(1);
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    audio_clk_en = 1'b0;
    phase_reset = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // One strobe, then wait (bounded) for out_valid; lat = edges after strobe edge.
  task automatic run_sample(input logic prst, output logic [15:0] o0,
                            output logic [15:0] o2, output int lat);
    audio_clk_en = 1'b1;
    phase_reset  = prst;
    tick();
    audio_clk_en = 1'b0;
    phase_reset  = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (ov0) begin
        lat = k;
        break;
      end
    end
    o0 = out0;
    o2 = out2;
  endtask

  // ---- behavioural reference ----
  longint m_phase [4];
  int     m_slew;

  function automatic int floor_div4(input int d);
    if (d >= 0) return d / 4;
    return -((-d + 3) / 4);
  endfunction

  task automatic model_sample(input logic prst, output int t0, output int t2);
    int sum;
    if (prst) for (int c = 0; c < 4; c++) m_phase[c] = 0;
    sum = 0;
    for (int c = 0; c < 4; c++) begin
      if (ch_enable[c]) begin
        m_phase[c] = (m_phase[c] + longint'(phase_inc[c*24 +: 24])) % 64'd16777216;
        if ((m_phase[c] / 65536) < longint'(duty[c*8 +: 8]))
          sum += int'(amplitude[c*16 +: 16]);
      end else begin
        m_phase[c] = 0;
      end
    end
    t0 = (sum > 65535) ? 65535 : sum;
    m_slew = m_slew + floor_div4(t0 - m_slew);
    t2 = m_slew;
  endtask

  // ---- vector table ----
  typedef struct {
    logic [95:0] inc;
    logic [31:0] dty;
    logic [63:0] amp;
    logic [3:0]  en;
    logic        prst;
    logic [15:0] exp_out;
  } vec_t;

  vec_t vecs [$];

  task automatic add_vec(input logic [95:0] inc, input logic [31:0] dty,
                         input logic [63:0] amp, input logic [3:0] en,
                         input logic prst, input logic [15:0] exp_out);
    vec_t v;
    v.inc = inc; v.dty = dty; v.amp = amp; v.en = en; v.prst = prst; v.exp_out = exp_out;
    vecs.push_back(v);
  endtask

  logic [15:0] o0, o2;
  int lat, t0, t2, bcnt, vcnt, vat;

  initial begin
    // single tone: 3 high, 4 low, then high again after wrap
    add_vec(96'h200000, 32'h80, 64'h4000, 4'b0001, 1'b1, 16'h4000);
    add_vec(96'h200000, 32'h80, 64'h4000, 4'b0001, 1'b0, 16'h4000);
    add_vec(96'h200000, 32'h80, 64'h4000, 4'b0001, 1'b0, 16'h4000);
    add_vec(96'h200000, 32'h80, 64'h4000, 4'b0001, 1'b0, 16'h0000);
    add_vec(96'h200000, 32'h80, 64'h4000, 4'b0001, 1'b0, 16'h0000);
    add_vec(96'h200000, 32'h80, 64'h4000, 4'b0001, 1'b0, 16'h0000);
    add_vec(96'h200000, 32'h80, 64'h4000, 4'b0001, 1'b0, 16'h0000);
    add_vec(96'h200000, 32'h80, 64'h4000, 4'b0001, 1'b0, 16'h4000);
    // saturation
    for (int i = 0; i < 3; i++)
      add_vec({4{24'h010000}}, 32'hFFFF_FFFF, {4{16'hFFFF}}, 4'b1111, (i == 0), 16'hFFFF);
    // duty 0 is always low
    add_vec(96'h200000, 32'h00, 64'hFFFF, 4'b0001, 1'b1, 16'h0000);
    add_vec(96'h200000, 32'h00, 64'hFFFF, 4'b0001, 1'b0, 16'h0000);
    // duty 255: low only when top phase byte is 0xFF
    add_vec(96'hFF0000, 32'hFF, 64'h1234, 4'b0001, 1'b1, 16'h0000);
    add_vec(96'hFF0000, 32'hFF, 64'h1234, 4'b0001, 1'b0, 16'h1234);
    // mixed: ch0 + ch2 high, ch1 duty 0, ch3 disabled
    add_vec(96'h0, 32'hFFFF_00FF, {16'hFFFF, 16'h2000, 16'h8000, 16'h1000}, 4'b0111, 1'b1, 16'h3000);

    do_reset();
    check("reset_out", 32'(out0), 32'h0);
    check("reset_valid", 32'(ov0), 32'h0);
    check("reset_busy", 32'(busy0), 32'h0);
    check("reset_overrun", 32'(orn0), 32'h0);

    foreach (vecs[i]) begin
      phase_inc = vecs[i].inc;
      duty      = vecs[i].dty;
      amplitude = vecs[i].amp;
      ch_enable = vecs[i].en;
      run_sample(vecs[i].prst, o0, o2, lat);
      check($sformatf("vec%0d_out", i), 32'(o0), 32'(vecs[i].exp_out));
      check($sformatf("vec%0d_latency", i), lat, 32'd5);
    end
    tick();
    check("valid_one_cycle", 32'(ov0), 32'h0);
    check("out_holds", 32'(out0), 32'h3000);

    // reset asserted mid-RUN, after an overrun
    audio_clk_en = 1'b1;
    tick();
    tick();
    audio_clk_en = 1'b0;
    tick();
    check("pre_reset_busy", 32'(busy0), 32'h1);
    check("pre_reset_overrun", 32'(orn0), 32'h1);
    reset_n = 1'b0;
    #1;
    check("async_reset_out", 32'(out0), 32'h0);
    check("async_reset_valid", 32'(ov0), 32'h0);
    check("async_reset_busy", 32'(busy0), 32'h0);
    check("async_reset_overrun", 32'(orn0), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    run_sample(1'b0, o0, o2, lat);
    check("post_reset_latency", lat, 32'd5);
    check("post_reset_out", 32'(o0), 32'h3000);

    // overrun: second strobe 2 clks after the first
    audio_clk_en = 1'b1;
    tick();
    audio_clk_en = 1'b0;
    bcnt = 0; vcnt = 0; vat = -1;
    for (int k = 0; k < 12; k++) begin
      if (busy0) bcnt++;
      if (ov0) begin vcnt++; vat = k; end
      audio_clk_en = (k == 1);
      tick();
    end
    audio_clk_en = 1'b0;
    check("overrun_set", 32'(orn0), 32'h1);
    check("overrun_busy_cycles", bcnt, 32'd5);
    check("overrun_valid_count", vcnt, 32'd1);
    check("overrun_valid_at", vat, 32'd5);
    run_sample(1'b0, o0, o2, lat);
    check("overrun_sticky", 32'(orn0), 32'h1);

    // phase_reset mid-RUN is deferred to the end of the sample
    do_reset();
    phase_inc = 96'h200000; duty = 32'h80; amplitude = 64'h4000; ch_enable = 4'b0001;
    for (int i = 0; i < 3; i++) run_sample(1'b0, o0, o2, lat);
    check("prst_setup", 32'(o0), 32'h4000);
    audio_clk_en = 1'b1;
    tick();
    audio_clk_en = 1'b0;
    tick();
    phase_reset = 1'b1;
    tick();
    phase_reset = 1'b0;
    lat = -1;
    for (int k = 3; k <= 20; k++) begin
      tick();
      if (ov0) begin lat = k; break; end
    end
    check("prst_midrun_latency", lat, 32'd5);
    check("prst_midrun_current", 32'(out0), 32'h0000);
    run_sample(1'b0, o0, o2, lat);
    check("prst_midrun_next", 32'(o0), 32'h4000);

    // disabled channel's phase is cleared
    phase_inc = {24'h0, 24'h0, 24'h200000, 24'h0};
    duty      = {8'h0, 8'h0, 8'h40, 8'h0};
    amplitude = {16'h0, 16'h0, 16'h0100, 16'h0};
    ch_enable = 4'b0010;
    run_sample(1'b1, o0, o2, lat);
    check("disable_first", 32'(o0), 32'h0100);
    ch_enable = 4'b0000;
    run_sample(1'b0, o0, o2, lat);
    check("disable_contrib", 32'(o0), 32'h0000);
    ch_enable = 4'b0010;
    run_sample(1'b0, o0, o2, lat);
    check("disable_phase_zeroed", 32'(o0), 32'h0100);

    // slew filter
    do_reset();
    phase_inc = 96'h1; duty = 32'hFF; amplitude = 64'h4000; ch_enable = 4'b0001;
    run_sample(1'b0, o0, o2, lat);
    check("slew_1", 32'(o2), 32'h1000);
    check("slew_unfiltered", 32'(o0), 32'h4000);
    run_sample(1'b0, o0, o2, lat);
    check("slew_2", 32'(o2), 32'h1C00);
    run_sample(1'b0, o0, o2, lat);
    check("slew_3", 32'(o2), 32'h2500);

    // randomized against the reference model
    do_reset();
    for (int c = 0; c < 4; c++) m_phase[c] = 0;
    m_slew = 0;
    for (int it = 0; it < 40; it++) begin
      logic prst;
      for (int c = 0; c < 4; c++) begin
        phase_inc[c*24 +: 24] = 24'($urandom_range(0, 24'hFFFFFF));
        duty[c*8 +: 8]        = 8'($urandom_range(0, 255));
        amplitude[c*16 +: 16] = 16'($urandom_range(0, 16'hFFFF));
        if (it % 4 == 0) amplitude[c*16 +: 16] = amplitude[c*16 +: 16] | 16'hC000;
      end
      ch_enable = 4'($urandom_range(0, 15));
      prst = ($urandom_range(0, 7) == 0);
      model_sample(prst, t0, t2);
      run_sample(prst, o0, o2, lat);
      check($sformatf("rand%0d_out", it), 32'(o0), 32'(t0));
      check($sformatf("rand%0d_slew", it), 32'(o2), 32'(t2));
      check($sformatf("rand%0d_latency", it), lat, 32'd5);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multichannel_square_wave_oscillator.md
Name: multichannel_square_wave_oscillator

Overview:
- Parametrised successor to the single inverter square-wave oscillator.
- Generates NUM_CHANNELS independent square waves, each with its own frequency, duty cycle, amplitude and enable.
- Mixes the channels with saturation and applies an optional first-order slew filter that models RC edge softening.
- One shared adder is time-multiplexed across channels. Output is an unsigned 16-bit audio sample, updated once per audio_clk_en strobe.

Parameters:
- NUM_CHANNELS, 4, number of oscillator channels (1..16).
- PHASE_BITS, 24, phase accumulator width; f_out = phase_inc * f_sample / 2^PHASE_BITS.
- SLEW_SHIFT, 0, slew filter shift; 0 disables the filter (output equals the mixed target).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- audio_clk_en  in  1  sample strobe, one clk wide.
- phase_inc  in  NUM_CHANNELS*PHASE_BITS  per-channel phase increment; channel i occupies bits [i*PHASE_BITS +: PHASE_BITS].
- duty  in  NUM_CHANNELS*8  per-channel duty threshold.
- amplitude  in  NUM_CHANNELS*16  per-channel high-level amplitude, unsigned.
- ch_enable  in  NUM_CHANNELS  per-channel enable.
- phase_reset  in  1  clears all phase accumulators.
- out  out  16  mixed audio sample, unsigned.
- out_valid  out  1  one-cycle pulse when out updates.
- busy  out  1  a sample is being computed.
- overrun  out  1  sticky; a strobe arrived while busy.

Behaviour:
- Reset (async, reset_n=0):
  - All phase registers, accumulator, out, out_valid, busy and overrun = 0.
  - State = IDLE.
- State machine: IDLE -> RUN -> MIX -> IDLE.
- IDLE:
  - On audio_clk_en=1: acc<=0, ch<=0, busy<=1, go to RUN. This edge is E0.
  - On phase_reset=1 in IDLE: all phases <=0 at that edge. If audio_clk_en is also high, the strobe is still accepted and the sample runs from zeroed phases.
- RUN, one channel per clk (edges E1..EN):
  - Channel ch disabled: phase[ch]<=0; contributes 0.
  - Channel ch enabled:
    - p = phase[ch] + phase_inc[ch], mod 2^PHASE_BITS (wraps silently); phase[ch]<=p.
    - level = (p[PHASE_BITS-1 -: 8] < duty[ch]).
    - acc <= acc + (level ? amplitude[ch] : 0).
  - Duty boundaries: duty=0 is always low; duty=255 is high for 255/256 of the period.
  - acc width = 16 + clog2(NUM_CHANNELS); never overflows.
  - After ch = NUM_CHANNELS-1, go to MIX.
- MIX (edge EN+1):
  - target = min(acc, 0xFFFF).
  - SLEW_SHIFT=0: out<=target.
  - SLEW_SHIFT>0: out <= out + ((target - out) >>> SLEW_SHIFT), using 18-bit signed arithmetic; the shift is arithmetic and truncates toward negative infinity.
  - out_valid<=1 for exactly one cycle; busy<=0; go to IDLE.
- Latency: out and out_valid are registered NUM_CHANNELS+1 clk edges after the accepting strobe edge.
- Minimum strobe period: NUM_CHANNELS+2 clks.
- audio_clk_en=1 while busy:
  - The strobe is ignored and overrun<=1. overrun stays set until reset.
  - A constantly-high strobe therefore runs back-to-back samples and sets overrun.
- phase_reset during RUN/MIX: latched as pending and applied in MIX (all phases <=0 after that sample's update). The current sample completes unchanged.
- Input stability: inputs are read in the channel's RUN cycle and must be held stable while busy=1. Changes take effect from the next sample.
- out holds its value between samples.

Decomposition:
- Package square_osc_pkg holds:
  - state enum (IDLE, RUN, MIX);
  - DUTY_BITS=8, AMP_BITS=16, OUT_WIDTH=16;
  - saturate_u16 function.
- Sub-module square_osc_slew_filter holds the MIX-stage filter: inputs target, strobe, SLEW_SHIFT parameter; registered output.

Test Plan:
- Reset: hold reset_n=0 mid-RUN -> out=0, out_valid=0, busy=0, overrun=0 immediately; after release, the first strobe produces out_valid at edge E5 (NUM_CHANNELS=4).
- Single tone: ch0 phase_inc=0x200000, duty=128, amp=0x4000, others disabled, strobe every 16 clks.
  - Outputs per sample: 0x4000 x3, 0 x4, then 0x4000 (wrap).
  - Pattern repeats with period 8 samples.
- Saturation: all 4 channels amp=0xFFFF, duty=255, phase_inc=0x10000 -> out=0xFFFF every sample; no wrap to a small value.
- Slew: SLEW_SHIFT=2, ch0 amp=0x4000, duty=255, phase_inc=1, out starting at 0 -> successive outputs 0x1000, 0x1C00, 0x2500.
- Overrun/latency: strobe, then a second strobe 2 clks later.
  - overrun=1 and stays set.
  - Only one out_valid, 5 clks after the first strobe.
  - busy high for 5 clks.
- phase_reset mid-RUN plus disable:
  - phase_reset asserted at E2 -> current sample unchanged; next sample computes from phase 0 (ch0 inc 0x200000 -> first output 0x4000).
  - ch_enable[1]=0 -> channel 1 contributes 0 and its phase reads 0.
